// File: rtl/seq_uart_tx.sv
// rtl/seq_uart_tx.sv - sequencer-driven UART transmitter with a byte FIFO and runtime divisor
// Define SEQUARTTX_PARITY_EN to add an even-parity bit after data bit 7.
module seq_uart_tx #(
    parameter logic [15:0] ClkDiv    = 16'd434,
    parameter int unsigned FifoDepth = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] inst,
    input  logic        inst_en,
    output logic        ready,
    output logic [7:0]  status,
    output logic        uart_tx
);
    localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned CntW = $clog2(FifoDepth + 1);

    localparam logic [3:0] OpSend   = 4'h1;
    localparam logic [3:0] OpDivL   = 4'h2;
    localparam logic [3:0] OpDivH   = 4'h3;
    localparam logic [3:0] OpClrErr = 4'h4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef SEQUARTTX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [7:0]        mem_q [FifoDepth];
    logic [7:0]        mem_d [FifoDepth];
    logic [15:0]       div_q, div_d, period_q, period_d, baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d, ovf_q, ovf_d;
`ifdef SEQUARTTX_PARITY_EN
    logic              par_q, par_d;
    localparam logic   ParityFlag = 1'b1;
`else
    localparam logic   ParityFlag = 1'b0;
`endif

    logic empty, full, bit_end, start, push, pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CntW'(FifoDepth));

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        mem_d    = mem_q;
        div_d    = div_q;
        period_d = period_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        ovf_d    = ovf_q;
`ifdef SEQUARTTX_PARITY_EN
        par_d    = par_q;
`endif
        start    = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        // period_q is never 0, so period_q - 1 cannot underflow
        bit_end  = (baud_q == period_q - 16'd1);
        baud_d   = (state_q == S_IDLE || bit_end) ? 16'd0 : baud_q + 16'd1;

        case (state_q)
            S_IDLE:  start = !empty;
            S_START: if (bit_end) begin
                state_d = S_DATA;
                bit_d   = 3'd0;
                tx_d    = shift_q[0];
                shift_d = {1'b0, shift_q[7:1]};
            end
            S_DATA: if (bit_end) begin
                if (bit_q == 3'd7) begin
`ifdef SEQUARTTX_PARITY_EN
                    state_d = S_PARITY;
                    tx_d    = par_q;
`else
                    state_d = S_STOP;
                    tx_d    = 1'b1;
`endif
                end else begin
                    bit_d   = bit_q + 3'd1;
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                end
            end
`ifdef SEQUARTTX_PARITY_EN
            S_PARITY: if (bit_end) begin
                state_d = S_STOP;
                tx_d    = 1'b1;
            end
`endif
            S_STOP: if (bit_end) begin
                if (!empty) start = 1'b1;
                else        state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Frame start: pop head byte and freeze the divisor for the whole frame
        if (start) begin
            pop      = 1'b1;
            state_d  = S_START;
            tx_d     = 1'b0;
            shift_d  = mem_q[rd_ptr_q];
            period_d = (div_q == 16'd0) ? 16'd1 : div_q;
            rd_ptr_d = (rd_ptr_q == PtrW'(FifoDepth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
`ifdef SEQUARTTX_PARITY_EN
            par_d    = ^mem_q[rd_ptr_q];
`endif
        end

        if (inst_en) begin
            case (inst[11:8])
                OpSend:   if (!full || pop) push = 1'b1; else ovf_d = 1'b1;
                OpDivL:   div_d[7:0]  = inst[7:0];
                OpDivH:   div_d[15:8] = inst[7:0];
                OpClrErr: ovf_d = 1'b0;
                default:  ;
            endcase
        end

        if (push) begin
            mem_d[wr_ptr_q] = inst[7:0];
            wr_ptr_d = (wr_ptr_q == PtrW'(FifoDepth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            mem_q    <= '{default: '0};
            div_q    <= ClkDiv;
            period_q <= 16'd1;
            baud_q   <= 16'd0;
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            tx_q     <= 1'b1;
            ovf_q    <= 1'b0;
`ifdef SEQUARTTX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            mem_q    <= mem_d;
            div_q    <= div_d;
            period_q <= period_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            ovf_q    <= ovf_d;
`ifdef SEQUARTTX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    assign ready   = !full;
    assign status  = {3'b000, ovf_q, (state_q != S_IDLE), full, empty, ParityFlag};
    assign uart_tx = tx_q;

endmodule

// File: tb/tb_seq_uart_tx.sv
// tb/tb_seq_uart_tx.sv - scoreboard bench for seq_uart_tx against a frame-level line model
module tb_seq_uart_tx;
    localparam logic [15:0] ClkDiv    = 16'd3;
    localparam int          FifoDepth = 4;
`ifdef SEQUARTTX_PARITY_EN
    localparam int          NB  = 11;
    localparam logic        PAR = 1'b1;
`else
    localparam int          NB  = 10;
    localparam logic        PAR = 1'b0;
`endif
    localparam logic [3:0] OP_NOP = 4'h0, OP_SEND = 4'h1, OP_DIVL = 4'h2,
                           OP_DIVH = 4'h3, OP_CLR = 4'h4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] inst = 12'h000;
    logic        inst_en = 1'b0;
    logic        ready;
    logic [7:0]  status;
    logic        uart_tx;

    seq_uart_tx #(.ClkDiv(ClkDiv), .FifoDepth(FifoDepth)) dut (
        .clock(clock), .reset(reset), .inst(inst), .inst_en(inst_en),
        .ready(ready), .status(status), .uart_tx(uart_tx)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];
    int div_edge[$];
    int div_val[$];
    int starts[$];
    int rd_idx = 0;
    bit in_frame = 1'b0;
    int cur_start = 0;
    int cur_p = 1;
    logic [15:0] model_div;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic int period_for(input int e);
        int v = 1;
        for (int i = 0; i < div_edge.size(); i++)
            if (div_edge[i] < e) v = div_val[i];
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int pending();
        return exp_q.size() - rd_idx;
    endfunction

    // Monitor: samples the line 1 time unit after every rising edge
    initial begin
        logic [10:0] fb;
        logic [7:0]  b;
        int          ferr;
        int          k;
        bit          prev_line;
        prev_line = 1'b1;
        ferr = 0;
        fb = '1;
        b = '0;
        forever begin
            @(posedge clock);
            cyc++;
            #1;
            if (!reset) begin
                in_frame  = 1'b0;
                rd_idx    = exp_q.size();
                prev_line = 1'b1;
            end else begin
                if (in_frame) begin
                    k = cyc - cur_start;
                    if (k < cur_p * NB) begin
                        if (uart_tx !== fb[k / cur_p]) ferr++;
                    end else begin
                        if (uart_tx === 1'b1 && status[3] !== 1'b0) ferr++;
                        chk($sformatf("frame %02h at period %0d bad samples", b, cur_p), ferr, 0);
                        in_frame = 1'b0;
                    end
                end
                if (!in_frame && prev_line === 1'b1 && uart_tx === 1'b0) begin
                    chk("frame start has queued byte", rd_idx < exp_q.size(), 1);
                    if (rd_idx < exp_q.size()) begin
                        b = exp_q[rd_idx];
                        rd_idx++;
                        cur_start = cyc;
                        cur_p = period_for(cyc);
                        fb = PAR ? {1'b1, ^b, b, 1'b0} : {1'b0, 1'b1, b, 1'b0};
                        ferr = 0;
                        in_frame = 1'b1;
                        starts.push_back(cyc);
                    end
                end
                prev_line = uart_tx;
            end
        end
    end

    task automatic op(input logic [3:0] o, input logic [7:0] d, input bit en, input bit accept);
        inst = {o, d};
        inst_en = en;
        if (en) begin
            case (o)
                OP_SEND: if (accept) exp_q.push_back(d);
                OP_DIVL: begin
                    model_div[7:0] = d;
                    div_edge.push_back(cyc + 1);
                    div_val.push_back(int'(model_div));
                end
                OP_DIVH: begin
                    model_div[15:8] = d;
                    div_edge.push_back(cyc + 1);
                    div_val.push_back(int'(model_div));
                end
                default: ;
            endcase
        end
        @(negedge clock);
        inst_en = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while ((in_frame || rd_idx != exp_q.size()) && n < limit) begin
            @(negedge clock);
            n++;
        end
        chk("drain within budget", n < limit, 1);
        @(negedge clock);
    endtask

    initial begin
        int t, n0, r;
        model_div = ClkDiv;
        div_edge.push_back(0);
        div_val.push_back(int'(ClkDiv));

        repeat (3) @(negedge clock);
        chk("reset uart_tx", uart_tx, 1);
        chk("reset ready", ready, 1);
        chk("reset status", status, {3'b000, 1'b0, 1'b0, 1'b0, 1'b1, PAR});
        reset = 1'b1;
        @(negedge clock);

        op(OP_SEND, 8'hC3, 1, 1);
        wait_drain(2000);

        op(OP_DIVL, 8'h04, 1, 0);
        op(OP_DIVH, 8'h00, 1, 0);
        op(OP_SEND, 8'h55, 1, 1);
        wait_drain(2000);

        n0 = starts.size();
        for (int i = 0; i < 5; i++) op(OP_SEND, 8'h10 + 8'(i), 1, 1);
        chk("overflow after five sends", status[4], 0);
        chk("full after five sends", status[2], 1);
        op(OP_SEND, 8'hEE, 1, 0);
        chk("overflow after dropped send", status[4], 1);
        chk("ready while full", ready, 0);
        op(OP_CLR, 8'h00, 1, 0);
        chk("overflow after clrerr", status[4], 0);
        t = cur_start + 4 * NB;
        for (int g = 0; g < 500 && cyc < t - 1; g++) @(negedge clock);
        chk("reached frame-end edge", cyc, t - 1);
        op(OP_SEND, 8'h5A, 1, 1);
        chk("overflow after send on pop edge", status[4], 0);
        chk("full after send on pop edge", status[2], 1);
        wait_drain(2000);
        for (int i = 0; i < 5; i++)
            chk("back-to-back spacing", starts[n0 + i + 1] - starts[n0 + i], 4 * NB);

        n0 = starts.size();
        op(OP_SEND, 8'hA5, 1, 1);
        op(OP_SEND, 8'h3C, 1, 1);
        wait_drain(2000);
        chk("A5->3C no idle gap", starts[n0 + 1] - starts[n0], 4 * NB);

        n0 = starts.size();
        op(OP_SEND, 8'h81, 1, 1);
        op(OP_SEND, 8'h42, 1, 1);
        repeat (10) @(negedge clock);
        op(OP_DIVL, 8'h08, 1, 0);
        wait_drain(2000);
        chk("divisor change waits for frame", starts[n0 + 1] - starts[n0], 4 * NB);

        op(OP_DIVL, 8'h00, 1, 0);
        op(OP_SEND, 8'h96, 1, 1);
        op(OP_SEND, 8'h07, 1, 1);
        wait_drain(2000);

        op(OP_DIVL, 8'h08, 1, 0);
        op(OP_SEND, 8'hF0, 1, 1);
        op(OP_SEND, 8'h0F, 1, 1);
        t = cur_start + 8 * 4 + 3;
        for (int g = 0; g < 500 && cyc < t; g++) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("uart_tx on reset", uart_tx, 1);
        chk("empty on reset", status[1], 1);
        chk("busy on reset", status[3], 0);
        chk("ready on reset", ready, 1);
        model_div = ClkDiv;
        div_edge.push_back(cyc);
        div_val.push_back(int'(ClkDiv));
        repeat (2) @(negedge clock);
        reset = 1'b1;
        n0 = starts.size();
        repeat (100) @(negedge clock);
        chk("no frame after reset", starts.size(), n0);
        chk("line idle after reset", uart_tx, 1);
        chk("busy idle after reset", status[3], 0);
        op(OP_SEND, 8'h3A, 1, 1);
        wait_drain(2000);

        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 6 && pending() < FifoDepth) op(OP_SEND, 8'($urandom), 1, 1);
            else if (r < 8)  op(OP_DIVL, 8'($urandom_range(0, 5)), 1, 0);
            else if (r < 9)  op(OP_DIVH, 8'h00, 1, 0);
            else if (r < 13) op(4'($urandom_range(5, 15)), 8'($urandom), 1, 0);
            else if (r < 17) op(OP_SEND, 8'($urandom), 0, 0);
            else if (r < 18) op(OP_CLR, 8'($urandom), 1, 0);
            else if (r < 20) op(OP_NOP, 8'($urandom), 1, 0);
            else @(negedge clock);
        end
        wait_drain(4000);
        chk("overflow after random phase", status[4], 0);
        chk("empty after random phase", status[1], 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_uart_tx.md
SEQ_UART_TX -- requirements
Module: SeqUartTx

Interface
REQ-001 SHALL have parameter ClkDiv, default 16'd434, reset value of the bit-period divisor in clocks.
REQ-002 SHALL have parameter FifoDepth, default 4, transmit FIFO depth in bytes, power of two.
REQ-003 SHALL have port clock  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port inst  input  12  sequencer instruction, opcode inst[11:8] and immediate inst[7:0].
REQ-006 SHALL have port inst_en  input  1  instruction valid strobe, one instruction per asserted cycle.
REQ-007 SHALL have port ready  output  1  high when the FIFO can accept a SEND.
REQ-008 SHALL have port status  output  8  {3'b000, overflow, busy, full, empty, parity_en}, for a sequencer ireg.
REQ-009 SHALL have port uart_tx  output  1  serial line, idle high.

Function
REQ-010 SHALL decode opcodes only when inst_en=1: 0x0 NOP; 0x1 SEND; 0x2 LDDIVL; 0x3 LDDIVH; 0x4 CLRERR; 0x5-0xF ignored, no state change.
REQ-011 SEND SHALL push inst[7:0] into the FIFO when not full; a SEND to a full FIFO SHALL be dropped and SHALL set the sticky overflow bit.
REQ-012 A SEND to a full FIFO in the same cycle as a frame-start pop SHALL be accepted, with no overflow.
REQ-013 LDDIVL/LDDIVH SHALL write divisor[7:0]/[15:8] and SHALL take effect at the next frame start only, never mid-frame.
REQ-014 CLRERR SHALL clear overflow; a SEND-overflow in the same cycle is impossible because only one instruction executes per cycle.
REQ-015 ready SHALL equal !full combinationally from registered FIFO count; empty/full SHALL be count==0/count==FifoDepth.
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY (only with macro), STOP.
REQ-017 IDLE SHALL move to START on the first edge where the FIFO is non-empty, popping the head byte into the shift register and latching the divisor in the same edge.
REQ-018 Each of START (uart_tx=0), DATA (8 bits, LSB first), PARITY, STOP (uart_tx=1) SHALL last exactly max(divisor,1) clocks per bit.
REQ-019 After STOP, the FSM SHALL go directly to START if the FIFO is non-empty (back-to-back frames, no idle gap), else to IDLE.
REQ-020 busy SHALL be high in every state except IDLE.
REQ-021 The bit counter and baud counter SHALL wrap without carry into adjacent fields; divisor 0 SHALL behave as divisor 1.
REQ-022 uart_tx SHALL be driven from a flop (glitch-free), changing only on bit boundaries.

Reset
REQ-023 Reset assertion SHALL immediately force uart_tx=1, state IDLE, FIFO empty, overflow=0, divisor=ClkDiv, regardless of any frame in progress.
REQ-024 Reset values SHALL be ready=1, status={3'b000,0,0,0,1,parity_en}.
REQ-025 A frame aborted by reset SHALL NOT resume after deassertion; FIFO content SHALL be discarded.

Configuration
REQ-026 With macro SEQUARTTX_PARITY_EN defined, frames SHALL include an even-parity bit after bit 7 (11-bit frame) and status[0]=1.
REQ-027 Without SEQUARTTX_PARITY_EN, PARITY state logic SHALL be absent, frames SHALL be 10 bits and status[0]=0.

Verification
REQ-028 Divisor=4 via LDDIVL 0x04/LDDIVH 0x00, SEND 0x55 -> uart_tx low 4 clocks, then 1,0,1,0,1,0,1,0 each 4 clocks, high 4 clocks; 40 clocks total without parity.
REQ-029 Five SENDs back-to-back while IDLE with FifoDepth=4 -> first pops at frame start, all five accepted, overflow=0; sixth SEND while full -> dropped, status[4]=1, ready=0.
REQ-030 Two queued bytes 0xA5, 0x3C -> STOP of first immediately followed by START of second, no idle clock between.
REQ-031 LDDIVL 0x08 issued mid-frame at divisor 4 -> current frame keeps 4 clocks/bit, next frame 8 clocks/bit.
REQ-032 Reset asserted during DATA bit 3 -> uart_tx=1 same cycle, empty=1, busy=0; after release, line idle until a new SEND.
REQ-033 With SEQUARTTX_PARITY_EN, SEND 0x07 -> parity bit 1, 11-bit frame; CLRERR after overflow -> status[4]=0.
